// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op codes seen from ID and the
// mode encodings understood by the combinational ALU.
package alu_pkg;

  // Operation codes delivered by the decoder. Codes 5 and 11-15 are unused.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_OR   = 4'd4,
    OP_AND  = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10
  } op_e;

  // Mode encodings of the combinational ALU.
  localparam logic [7:0] MODE_ADD  = 8'd0;
  localparam logic [7:0] MODE_SUB  = 8'd1;
  localparam logic [7:0] MODE_SLT  = 8'd2;
  localparam logic [7:0] MODE_SLTU = 8'd3;
  localparam logic [7:0] MODE_OR   = 8'd4;
  localparam logic [7:0] MODE_AND  = 8'd6;
  localparam logic [7:0] MODE_XOR  = 8'd7;
  localparam logic [7:0] MODE_SLL  = 8'd8;
  localparam logic [7:0] MODE_SR   = 8'd10;

endpackage

// File: rtl/alu_operand_prep.sv
// Combinational operand preparation: maps the op to an ALU mode, selects the
// operand sources and applies the RV64 fix-ups the ALU cannot do by itself
// (signed compare via sign-bit flip, arithmetic shift via invert/shift/invert,
// shift-amount masking, W-op operand extension) and flags illegal ops.
module alu_operand_prep
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [3:0]      op_i,
  input  logic            word_i,
  input  logic            src1_pc_i,
  input  logic            src2_imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [7:0]      mode_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic            inv_o,
  output logic            err_o
);

  logic [XLEN-1:0] a_sel;
  logic [XLEN-1:0] b_sel;
  logic [XLEN-1:0] a_sext_w;
  logic [XLEN-1:0] a_zext_w;
  logic [XLEN-1:0] shamt;
  logic [XLEN-1:0] a_sra;
  logic            illegal_op;
  logic            word_ok;

  // Source selection and the word-sized views of the operands.
  always_comb begin
    a_sel    = src1_pc_i  ? pc_i  : rs1_i;
    b_sel    = src2_imm_i ? imm_i : rs2_i;
    a_sext_w = {{(XLEN-32){a_sel[31]}}, a_sel[31:0]};
    a_zext_w = {{(XLEN-32){1'b0}}, a_sel[31:0]};
    // W shifts only honour five amount bits, full-width shifts six.
    shamt    = word_i ? {{(XLEN-5){1'b0}}, b_sel[4:0]}
                      : {{(XLEN-6){1'b0}}, b_sel[5:0]};
  end

  // Op decode: ALU mode, transformed operands, result-invert flag and legality.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned and infers a latch.
    mode_o     = MODE_ADD;
    a_o        = a_sel;
    b_o        = b_sel;
    inv_o      = 1'b0;
    illegal_op = 1'b0;
    word_ok    = 1'b0;
    a_sra      = word_i ? a_sext_w : a_sel;

    case (op_i)
      OP_ADD: begin
        mode_o  = MODE_ADD;
        word_ok = 1'b1;
      end
      OP_SUB: begin
        mode_o  = MODE_SUB;
        word_ok = 1'b1;
      end
      OP_SLT: begin
        // Flipping both sign bits turns a signed compare into an unsigned one.
        mode_o = MODE_SLTU;
        a_o    = {~a_sel[XLEN-1], a_sel[XLEN-2:0]};
        b_o    = {~b_sel[XLEN-1], b_sel[XLEN-2:0]};
      end
      OP_SLTU: mode_o = MODE_SLTU;
      OP_OR:   mode_o = MODE_OR;
      OP_AND:  mode_o = MODE_AND;
      OP_XOR:  mode_o = MODE_XOR;
      OP_SLL: begin
        mode_o  = MODE_SLL;
        b_o     = shamt;
        word_ok = 1'b1;
      end
      OP_SRL: begin
        mode_o  = MODE_SR;
        a_o     = word_i ? a_zext_w : a_sel;
        b_o     = shamt;
        word_ok = 1'b1;
      end
      OP_SRA: begin
        // A negative value is shifted as its complement (zeros shift in) and
        // the result is complemented back, giving an arithmetic shift.
        mode_o  = MODE_SR;
        b_o     = shamt;
        word_ok = 1'b1;
        if (a_sra[XLEN-1]) begin
          a_o   = ~a_sra;
          inv_o = 1'b1;
        end else begin
          a_o   = a_sra;
        end
      end
      default: illegal_op = 1'b1;
    endcase

    err_o = illegal_op || (word_i && !word_ok);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage execute front end. S1 registers the prepared ALU inputs and
// drives the external ALU; S2 captures the post-processed ALU result for WB.
// Both stages use valid/ready handshakes; flush empties the pipe.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic            in_word,
  input  logic            in_src1_pc,
  input  logic            in_src2_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [TAGW-1:0] in_rd,
  output logic [7:0]      alu_mode,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_rd,
  output logic            out_err
);

  // Prepared operands from the combinational decode.
  logic [7:0]      prep_mode;
  logic [XLEN-1:0] prep_a;
  logic [XLEN-1:0] prep_b;
  logic            prep_inv;
  logic            prep_err;

  // S1 state.
  logic            s1_valid_q, s1_valid_d;
  logic [7:0]      mode_q, mode_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            inv_q, inv_d;
  logic            word_q, word_d;
  logic            err_q, err_d;
  logic [TAGW-1:0] rd_q, rd_d;

  // S2 state.
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [TAGW-1:0] out_rd_q, out_rd_d;
  logic            out_err_q, out_err_d;

  // Handshake and datapath helpers.
  logic            s1_load;
  logic            s2_load;
  logic            s1_advance;
  logic [XLEN-1:0] post_result;

  alu_operand_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .op_i       (in_op),
    .word_i     (in_word),
    .src1_pc_i  (in_src1_pc),
    .src2_imm_i (in_src2_imm),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .imm_i      (in_imm),
    .pc_i       (in_pc),
    .mode_o     (prep_mode),
    .a_o        (prep_a),
    .b_o        (prep_b),
    .inv_o      (prep_inv),
    .err_o      (prep_err)
  );

  // Handshake: S2 fills when it is empty or draining; S1 refills behind it.
  // Flush blocks every load and drops in_ready for that cycle.
  always_comb begin
    s2_load    = s1_valid_q && (!s2_valid_q || out_ready) && !flush;
    s1_advance = s2_load;
    in_ready   = !flush && (!s1_valid_q || s1_advance);
    s1_load    = in_valid && in_ready;
  end

  // Result fix-up: undo the SRA complement, sign-extend W results, zero errors.
  always_comb begin
    post_result = alu_z;
    if (inv_q) begin
      post_result = ~post_result;
    end
    if (word_q) begin
      post_result = {{(XLEN-32){post_result[31]}}, post_result[31:0]};
    end
    if (err_q) begin
      post_result = '0;
    end
  end

  // Next-state for both stages; data registers hold unless their stage loads.
  always_comb begin
    s1_valid_d = s1_valid_q;
    mode_d     = mode_q;
    a_d        = a_q;
    b_d        = b_q;
    inv_d      = inv_q;
    word_d     = word_q;
    err_d      = err_q;
    rd_d       = rd_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    out_rd_d   = out_rd_q;
    out_err_d  = out_err_q;

    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (s1_load) begin
      mode_d = prep_mode;
      a_d    = prep_a;
      b_d    = prep_b;
      inv_d  = prep_inv;
      word_d = in_word;
      err_d  = prep_err;
      rd_d   = in_rd;
    end

    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (s2_load) begin
      result_d  = post_result;
      out_rd_d  = rd_q;
      out_err_d = err_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset along with the valids because
    // they drive ports directly and must read 0 after rst.
    if (rst) begin
      s1_valid_q <= 1'b0;
      mode_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      inv_q      <= 1'b0;
      word_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      out_rd_q   <= '0;
      out_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      s1_valid_q <= s1_valid_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      inv_q      <= inv_d;
      word_q     <= word_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      out_rd_q   <= out_rd_d;
      out_err_q  <= out_err_d;
    end
  end

  assign alu_mode   = mode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_rd     = out_rd_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage. A behavioural ALU closes the loop
// on alu_mode/alu_a/alu_b -> alu_z; expected results come from a reference
// model of RV64 integer semantics applied directly to the selected operands.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int XLEN = 64;
  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_op = '0;
  logic            in_word = 1'b0;
  logic            in_src1_pc = 1'b0;
  logic            in_src2_imm = 1'b0;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic [TAGW-1:0] in_rd = '0;
  logic [7:0]      alu_mode;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_z;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_result;
  logic [TAGW-1:0] out_rd;
  logic            out_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [TAGW-1:0] rd;
    logic            err;
  } exp_t;

  always #5 clk = ~clk;

  alu_issue_stage #(
    .XLEN (XLEN),
    .TAGW (TAGW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_word     (in_word),
    .in_src1_pc  (in_src1_pc),
    .in_src2_imm (in_src2_imm),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .in_rd       (in_rd),
    .alu_mode    (alu_mode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_z       (alu_z),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_err     (out_err)
  );

  // The team's combinational ALU, as seen from this stage.
  function automatic logic [XLEN-1:0] alu_fn(input logic [7:0] m,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (m)
      8'd0:    return a + b;
      8'd1:    return a - b;
      8'd2:    return (sa < sb) ? 64'd1 : 64'd0;
      8'd3:    return (a < b) ? 64'd1 : 64'd0;
      8'd4:    return a | b;
      8'd6:    return a & b;
      8'd7:    return a ^ b;
      8'd8:    return a << b[5:0];
      8'd10:   return a >> b[5:0];
      default: return '0;
    endcase
  endfunction

  always_comb alu_z = alu_fn(alu_mode, alu_a, alu_b);

  // RV64 reference: returns {err, result}.
  function automatic logic [XLEN:0] ref_model(input logic [3:0] op,
                                              input logic word,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0]        r;
    logic [31:0]            r32;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic signed [31:0]     sa32;
    logic                   legal;
    logic                   word_legal;
    sa = a;
    sb = b;
    sa32 = a[31:0];
    r = '0;
    r32 = '0;
    legal = 1'b1;
    word_legal = 1'b1;
    case (op)
      4'd0:  begin r = a + b; r32 = a[31:0] + b[31:0]; end
      4'd1:  begin r = a - b; r32 = a[31:0] - b[31:0]; end
      4'd2:  begin r = (sa < sb) ? 64'd1 : 64'd0; word_legal = 1'b0; end
      4'd3:  begin r = (a < b) ? 64'd1 : 64'd0; word_legal = 1'b0; end
      4'd4:  begin r = a | b; word_legal = 1'b0; end
      4'd6:  begin r = a & b; word_legal = 1'b0; end
      4'd7:  begin r = a ^ b; word_legal = 1'b0; end
      4'd8:  begin r = a << b[5:0]; r32 = a[31:0] << b[4:0]; end
      4'd9:  begin r = a >> b[5:0]; r32 = a[31:0] >> b[4:0]; end
      4'd10: begin r = sa >>> b[5:0]; r32 = sa32 >>> b[4:0]; end
      default: legal = 1'b0;
    endcase
    if (!legal || (word && !word_legal)) return {1'b1, 64'd0};
    if (word) r = {{32{r32[31]}}, r32};
    return {1'b0, r};
  endfunction

  // ALU mode the spec assigns to each legal op.
  function automatic logic [7:0] spec_mode(input logic [3:0] op);
    case (op)
      4'd0:    return 8'd0;
      4'd1:    return 8'd1;
      4'd2:    return 8'd3;
      4'd3:    return 8'd3;
      4'd4:    return 8'd4;
      4'd6:    return 8'd6;
      4'd7:    return 8'd7;
      4'd8:    return 8'd8;
      4'd9:    return 8'd10;
      4'd10:   return 8'd10;
      default: return 8'd255;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] rand64();
    case ($urandom_range(5))
      0:       return '0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_8000_0000;
      4:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_op(input logic [3:0] op, input logic word,
                        input logic s1pc, input logic s2imm,
                        input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                        input logic [TAGW-1:0] rd);
    in_op = op;
    in_word = word;
    in_src1_pc = s1pc;
    in_src2_imm = s2imm;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
    in_pc = pc;
    in_rd = rd;
  endtask

  // Offer one op into an empty pipe and wait (bounded) for its result.
  task automatic issue_one(input logic [3:0] op, input logic word,
                           input logic s1pc, input logic s2imm,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                           input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                           input logic [TAGW-1:0] rd,
                           output logic [XLEN-1:0] res, output logic err,
                           output logic [TAGW-1:0] rd_seen,
                           output int lat, output logic [7:0] mode_seen);
    @(negedge clk);
    set_op(op, word, s1pc, s2imm, rs1, rs2, imm, pc, rd);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mode_seen = alu_mode;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    err = out_err;
    rd_seen = out_rd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset out_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (out_result !== '0 || out_rd !== '0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: got result=%h rd=%0d err=%b want 0", out_result, out_rd, out_err);
    end
    vectors++;
    if (alu_mode !== '0 || alu_a !== '0 || alu_b !== '0) begin
      miscompares++;
      $display("FAIL reset alu: got mode=%0d a=%h b=%h want 0", alu_mode, alu_a, alu_b);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
  endtask

  typedef struct {
    logic [3:0]      op;
    logic            word;
    logic            s1pc;
    logic            s2imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] res;
    logic            err;
  } dir_t;

  task automatic test_directed();
    dir_t dv[13];
    logic [XLEN-1:0] res;
    logic err;
    logic [TAGW-1:0] rd_seen;
    logic [7:0] mode_seen;
    logic [7:0] last_mode;
    int lat;
    dv[0]  = '{OP_SLT,  1'b0, 1'b0, 1'b0, '1, 64'd1, 64'd0, 64'd0, 64'd1, 1'b0};
    dv[1]  = '{OP_SLTU, 1'b0, 1'b0, 1'b0, '1, 64'd1, 64'd0, 64'd0, 64'd0, 1'b0};
    dv[2]  = '{OP_SRA,  1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 64'd0,
               64'hF800_0000_0000_0000, 1'b0};
    dv[3]  = '{OP_SRL,  1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 64'd0,
               64'h0800_0000_0000_0000, 1'b0};
    dv[4]  = '{OP_SUB,  1'b1, 1'b0, 1'b0, 64'd0, 64'd1, 64'd0, 64'd0, '1, 1'b0};
    dv[5]  = '{OP_SRA,  1'b1, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h21, 64'd0, 64'd0,
               64'hFFFF_FFFF_C000_0000, 1'b0};
    dv[6]  = '{4'd5,    1'b0, 1'b0, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0, 64'd0, 1'b1};
    dv[7]  = '{OP_AND,  1'b1, 1'b0, 1'b0, '1, '1, 64'd0, 64'd0, 64'd0, 1'b1};
    dv[8]  = '{OP_ADD,  1'b0, 1'b1, 1'b1, 64'hDEAD, 64'd5, 64'h20, 64'h1000, 64'h1020, 1'b0};
    dv[9]  = '{OP_SLL,  1'b1, 1'b0, 1'b0, 64'd1, 64'd31, 64'd0, 64'd0,
               64'hFFFF_FFFF_8000_0000, 1'b0};
    dv[10] = '{OP_SRL,  1'b1, 1'b0, 1'b0, '1, 64'd4, 64'd0, 64'd0,
               64'h0000_0000_0FFF_FFFF, 1'b0};
    dv[11] = '{OP_SLL,  1'b0, 1'b0, 1'b0, 64'd1, 64'h41, 64'd0, 64'd0, 64'd2, 1'b0};
    dv[12] = '{OP_SRA,  1'b0, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 64'd1, 64'd0, 64'd0,
               64'h2000_0000_0000_0000, 1'b0};
    last_mode = '0;
    for (int i = 0; i < 13; i++) begin
      issue_one(dv[i].op, dv[i].word, dv[i].s1pc, dv[i].s2imm, dv[i].rs1, dv[i].rs2,
                dv[i].imm, dv[i].pc, TAGW'(i + 1), res, err, rd_seen, lat, mode_seen);
      vectors++;
      if (lat != 2) begin
        miscompares++;
        $display("FAIL directed[%0d] latency: got %0d want 2", i, lat);
      end
      vectors++;
      if (res !== dv[i].res || err !== dv[i].err) begin
        miscompares++;
        $display("FAIL directed[%0d] result: got %h err=%b want %h err=%b",
                 i, res, err, dv[i].res, dv[i].err);
      end
      vectors++;
      if (rd_seen !== TAGW'(i + 1)) begin
        miscompares++;
        $display("FAIL directed[%0d] rd: got %0d want %0d", i, rd_seen, i + 1);
      end
      if (!dv[i].err) begin
        vectors++;
        if (mode_seen !== spec_mode(dv[i].op)) begin
          miscompares++;
          $display("FAIL directed[%0d] alu_mode: got %0d want %0d", i, mode_seen, spec_mode(dv[i].op));
        end
        last_mode = spec_mode(dv[i].op);
      end
    end
    // S1 is empty now; the ALU drive must keep the last op's mode.
    vectors++;
    if (alu_mode !== last_mode) begin
      miscompares++;
      $display("FAIL alu_mode hold: got %0d want %0d", alu_mode, last_mode);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_q[$];
    int idx;
    int got;
    logic stall_seen;
    idx = 0;
    got = 0;
    stall_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      if (idx < 4) begin
        set_op(OP_ADD, 1'b0, 1'b0, 1'b0, 64'(idx), 64'(idx + 1), 64'd0, 64'd0, TAGW'(idx));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (exp_q.size() == 2 && !out_ready) begin
        stall_seen = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stream in_ready while full: got %b want 0", in_ready);
        end
      end
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL stream extra output: got %h want none", out_result);
        end else if (out_result !== exp_q[0]) begin
          miscompares++;
          $display("FAIL stream result: got %h want %h", out_result, exp_q[0]);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(64'(2 * idx + 1));
        idx++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 4 || !stall_seen) begin
      miscompares++;
      $display("FAIL stream completion: got %0d results stall=%b want 4 stall=1", got, stall_seen);
    end
  endtask

  task automatic test_random();
    exp_t exp_q[$];
    exp_t e;
    exp_t hd;
    logic [XLEN:0] m;
    int issued;
    issued = 0;
    for (int c = 0; c < 4000 && (issued < 300 || exp_q.size() > 0); c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < 70) || (issued >= 300);
      if (issued < 300 && $urandom_range(99) < 75) begin
        if ($urandom_range(9) < 8) begin
          case ($urandom_range(9))
            0: in_op = OP_ADD;  1: in_op = OP_SUB;  2: in_op = OP_SLT;
            3: in_op = OP_SLTU; 4: in_op = OP_OR;   5: in_op = OP_AND;
            6: in_op = OP_XOR;  7: in_op = OP_SLL;  8: in_op = OP_SRL;
            default: in_op = OP_SRA;
          endcase
        end else begin
          in_op = 4'($urandom_range(15));
        end
        in_word = ($urandom_range(9) < 3);
        in_src1_pc = ($urandom_range(9) < 2);
        in_src2_imm = ($urandom_range(9) < 3);
        in_rs1 = rand64();
        in_rs2 = rand64();
        in_imm = rand64();
        in_pc = rand64();
        in_rd = TAGW'($urandom_range(31));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL random unexpected output: got %h want none", out_result);
        end else begin
          hd = exp_q.pop_front();
          if (out_result !== hd.result || out_rd !== hd.rd || out_err !== hd.err) begin
            miscompares++;
            $display("FAIL random result: got %h rd=%0d err=%b want %h rd=%0d err=%b",
                     out_result, out_rd, out_err, hd.result, hd.rd, hd.err);
          end
        end
      end
      if (in_valid && in_ready) begin
        m = ref_model(in_op, in_word, in_src1_pc ? in_pc : in_rs1,
                      in_src2_imm ? in_imm : in_rs2);
        e.result = m[XLEN-1:0];
        e.err = m[XLEN];
        e.rd = in_rd;
        exp_q.push_back(e);
        issued++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (issued != 300 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random drain: got issued=%0d pending=%0d want 300/0", issued, exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic leaked;
    @(negedge clk);
    out_ready = 1'b0;
    set_op(OP_ADD, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 5'd1);
    in_valid = 1'b1;
    @(negedge clk);
    set_op(OP_ADD, 1'b0, 1'b0, 1'b0, 64'd2, 64'd2, 64'd0, 64'd0, 5'd2);
    @(negedge clk);
    flush = 1'b1;
    set_op(OP_ADD, 1'b0, 1'b0, 1'b0, 64'd5, 64'd5, 64'd0, 64'd0, 5'd3);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush cycle: got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush out_valid: got %b want 0", out_valid);
    end
    leaked = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) leaked = 1'b1;
    end
    vectors++;
    if (leaked !== 1'b0) begin
      miscompares++;
      $display("FAIL flush offered op accepted: got out_valid later=%b want 0", leaked);
    end
  endtask

  task automatic test_rst_midstream();
    logic leaked;
    @(negedge clk);
    out_ready = 1'b0;
    set_op(OP_AND, 1'b1, 1'b0, 1'b0, '1, '1, 64'd0, 64'd0, 5'd7);
    in_valid = 1'b1;
    @(negedge clk);
    set_op(OP_ADD, 1'b0, 1'b0, 1'b0, 64'h1234, 64'h5678, 64'd0, 64'd0, 5'd9);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rd !== 5'd7) begin
      miscompares++;
      $display("FAIL pre-reset state: got valid=%b err=%b rd=%0d want 1/1/7", out_valid, out_err, out_rd);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_rd !== '0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid reset outputs: got valid=%b result=%h rd=%0d err=%b want 0",
               out_valid, out_result, out_rd, out_err);
    end
    vectors++;
    if (alu_mode !== '0 || alu_a !== '0 || alu_b !== '0) begin
      miscompares++;
      $display("FAIL mid reset alu: got mode=%0d a=%h b=%h want 0", alu_mode, alu_a, alu_b);
    end
    leaked = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) leaked = 1'b1;
    end
    vectors++;
    if (leaked !== 1'b0) begin
      miscompares++;
      $display("FAIL mid reset S1 survived: got out_valid later=%b want 0", leaked);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_rst_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
